// File: rtl/mem_access_stage.sv
//------------------------------------------------------------------------------
// mem_access_stage : MEM stage, runs EX/MEM loads/stores over a req/ack data
//                    port and emits the registered MEM/WB bundle.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_stage #(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [70:0]       ex_mem_in,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic [35:0]       mem_wb_out,
   output logic              misalign,
   output logic              bus_err
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [3:0] c_cnt_last = 4'(TIMEOUT - 1);

   logic        w_reg_write, w_mem_to_reg, w_mem_read, w_mem_write, w_mem_op;
   logic [31:0] w_alu, w_sdata;
   logic [2:0]  w_rd;

   assign w_reg_write  = ex_mem_in[70];
   assign w_mem_to_reg = ex_mem_in[69];
   assign w_mem_read   = ex_mem_in[68];
   assign w_mem_write  = ex_mem_in[67];
   assign w_alu        = ex_mem_in[66:35];
   assign w_sdata      = ex_mem_in[34:3];
   assign w_rd         = ex_mem_in[2:0];
   assign w_mem_op     = w_mem_read | w_mem_write;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [35:0]       wb_q, wb_d;
   logic              mis_q, mis_d, berr_q, berr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wb_d    = '0;
      mis_d   = 1'b0;
      berr_d  = 1'b0;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_mem_op) begin
               stall   = 1'b1;
               state_d = ACCESS;
               req_d   = 1'b1;
               we_d    = w_mem_write;
               addr_d  = w_alu[ADDR_W+1:2];
               wdata_d = w_sdata;
               cnt_d   = 4'd0;
               mis_d   = |w_alu[1:0];
            end else begin
               wb_d = {w_reg_write, w_rd, w_alu};
            end
         end
         ACCESS: begin
            if (dmem_ack) begin
               state_d = IDLE;
               req_d   = 1'b0;
               // A set write bit turns the op into a store, so no read data.
               if (w_mem_read && !w_mem_write && w_mem_to_reg)
                  wb_d = {w_reg_write, w_rd, dmem_rdata};
               else
                  wb_d = {w_reg_write, w_rd, w_alu};
            end else if (cnt_q == c_cnt_last) begin
               state_d = IDLE;
               req_d   = 1'b0;
               berr_d  = 1'b1;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wb_q    <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wb_q    <= wb_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign mem_wb_out = wb_q;
   assign misalign   = mis_q;
   assign bus_err    = berr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
//------------------------------------------------------------------------------
// tb_mem_access_stage : directed plus random transactions against a
//                       transaction-level expectation of the MEM stage.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_stage;

   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic [70:0]       ex_mem_in;
   logic              stall, dmem_req, dmem_we, misalign, bus_err, dmem_ack;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata, dmem_rdata;
   logic [35:0]       mem_wb_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .ex_mem_in  (ex_mem_in),
      .stall      (stall),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .mem_wb_out (mem_wb_out),
      .misalign   (misalign),
      .bus_err    (bus_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [70:0] bundle(input logic rw, m2r, rd_en, wr_en,
                                          input logic [31:0] alu, sd,
                                          input logic [2:0] rd);
      return {rw, m2r, rd_en, wr_en, alu, sd, rd};
   endfunction

   // Non-memory op: one cycle, ALU result forwarded.
   task automatic run_alu(input logic rw, input logic [2:0] rd, input logic [31:0] alu);
      ex_mem_in = bundle(rw, 1'b0, 1'b0, 1'b0, alu, $urandom, rd);
      dmem_ack  = 1'b0;
      #1;
      chk("alu_stall", stall, 0);
      step();
      chk("alu_wb", mem_wb_out, {rw, rd, alu});
      chk("alu_req", dmem_req, 0);
      chk("alu_berr", bus_err, 0);
      chk("alu_mis", misalign, 0);
   endtask

   // Memory op acknowledged after nwait no-ack cycles; nwait >= TIMEOUT never acks.
   task automatic run_mem(input logic rw, m2r, rd_en, wr_en, input logic [2:0] rd,
                          input logic [31:0] alu, sd, rdata, input int nwait);
      logic [ADDR_W-1:0] exp_addr;
      logic [35:0]       exp_wb;
      exp_addr  = ADDR_W'(alu / 4);
      exp_wb    = (rd_en && !wr_en && m2r) ? {rw, rd, rdata} : {rw, rd, alu};
      ex_mem_in = bundle(rw, m2r, rd_en, wr_en, alu, sd, rd);
      dmem_ack  = 1'b0;
      #1;
      chk("iss_stall", stall, 1);
      step();
      chk("iss_req", dmem_req, 1);
      chk("iss_mis", misalign, (alu % 4) != 0);
      chk("iss_wb", mem_wb_out, 0);
      for (int k = 0; k < TIMEOUT; k++) begin
         chk("acc_addr", dmem_addr, exp_addr);
         chk("acc_we", dmem_we, wr_en);
         if (wr_en) chk("acc_wdata", dmem_wdata, sd);
         if (k == nwait) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            #1;
            chk("ack_stall", stall, 0);
            step();
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            chk("ack_req", dmem_req, 0);
            chk("ack_wb", mem_wb_out, exp_wb);
            chk("ack_berr", bus_err, 0);
            return;
         end
         #1;
         chk("wait_stall", stall, (k == TIMEOUT - 1) ? 1'b0 : 1'b1);
         step();
         chk("wait_wb", mem_wb_out, 0);
         chk("wait_mis", misalign, 0);
         chk("wait_req", dmem_req, (k == TIMEOUT - 1) ? 1'b0 : 1'b1);
         chk("wait_berr", bus_err, (k == TIMEOUT - 1) ? 1'b1 : 1'b0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      ex_mem_in  = '0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      step();
      step();
      chk("rst_req", dmem_req, 0);
      chk("rst_wb", mem_wb_out, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_flags", {misalign, bus_err}, 0);
      rst = 1'b0;

      run_alu(1'b1, 3'd5, 32'h0000_1234);
      run_mem(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 32'h40, 32'h0, 32'hDEAD_BEEF, 1);
      run_mem(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h8, 32'hA5A5_A5A5, 32'h0, 3);
      run_mem(1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 32'h100, 32'h0, 32'h0, TIMEOUT);
      run_alu(1'b1, 3'd1, 32'h0BAD_F00D);
      run_mem(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h13, 32'h1111_2222, 32'h0, 0);
      run_mem(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 32'h24, 32'h0, 32'h1357_9BDF, 0);
      // Both mem bits set: behaves as a store, write-back keeps the ALU value.
      run_mem(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 32'hFFC, 32'h7777_0000, 32'hFFFF_FFFF, 2);
      // Ack on the last permitted wait cycle still completes normally.
      run_mem(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 32'h3FC, 32'h0, 32'hCAFE_0001, TIMEOUT - 1);

      // Reset mid-access, then a late ack must be ignored.
      ex_mem_in = bundle(1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 3'd2);
      step();
      step();
      chk("mid_req", dmem_req, 1);
      rst = 1'b1;
      step();
      rst       = 1'b0;
      ex_mem_in = '0;
      chk("rst_mid_req", dmem_req, 0);
      chk("rst_mid_wb", mem_wb_out, 0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1234_5678;
      #1;
      chk("late_stall", stall, 0);
      step();
      dmem_ack = 1'b0;
      chk("late_req", dmem_req, 0);
      chk("late_wb", mem_wb_out, 0);

      for (int n = 0; n < 150; n++) begin
         logic [31:0] alu, sd, rdata;
         logic [2:0]  rd;
         logic        rw, m2r, rd_en, wr_en;
         int          nwait, kind;
         alu   = $urandom;
         sd    = $urandom;
         rdata = $urandom;
         rd    = 3'($urandom);
         rw    = 1'($urandom);
         m2r   = 1'($urandom);
         kind  = int'($urandom_range(0, 9));
         nwait = (kind == 9) ? TIMEOUT : int'($urandom_range(0, 4));
         if (kind < 3) begin
            run_alu(rw, rd, alu);
         end else begin
            rd_en = (kind != 4);
            wr_en = (kind >= 4 && kind <= 6);
            run_mem(rw, m2r, rd_en, wr_en, rd, alu, sd, rdata, nwait);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
